axil_mux_wr: RTL and testbench
==============================

// Module: axil_mux_wr
// PURPOSE
//  Write-path multiplexer of the AXI-Lite interconnect; sits between the masters and the single slave port.
//  Drives request_wr into the write arbiter and consumes the one-hot grant_wr it returns.
//  Routes AW and W of the granted master to the slave port and returns B to that master.
//  Tracks AW/W/B completion so each granted transaction is forwarded exactly once.
// PARAMETERS
//  NUMBER_MASTER    2   number of master ports (from axil_pkg); sel index width = $clog2(NUMBER_MASTER)
//  AXIL_ADDR_WIDTH  32  AW address width
//  AXIL_DATA_WIDTH  32  W data width; wstrb width = AXIL_DATA_WIDTH/8
// PORTS
//  aclk             in   1        clock; all logic on rising edge
//  aresetn          in   1        reset, synchronous, active-low
//  request_wr       out  NM       to arbiter: request_wr[i] = m_axil_awvalid[i]
//  grant_wr         in   NM       from arbiter: one-hot grant, 0 = no grant
//  m_axil_awaddr    in   NM*AW    per-master AW address, packed [NM-1:0][AW-1:0]
//  m_axil_awvalid   in   NM       per-master AW valid
//  m_axil_awready   out  NM       per-master AW ready
//  m_axil_wdata     in   NM*DW    per-master W data
//  m_axil_wstrb     in   NM*DW/8  per-master W strobe
//  m_axil_wvalid    in   NM       per-master W valid
//  m_axil_wready    out  NM       per-master W ready
//  m_axil_bresp     out  NM*2     per-master B response; s_axil_bresp broadcast to all lanes
//  m_axil_bvalid    out  NM       per-master B valid
//  m_axil_bready    in   NM       per-master B ready (also observed by arbiter)
//  s_axil_awaddr/awvalid out, s_axil_awready in   slave AW channel
//  s_axil_wdata/wstrb/wvalid out, s_axil_wready in  slave W channel
//  s_axil_bresp/bvalid in, s_axil_bready out        slave B channel
// BEHAVIOUR
//  - sel = index of the set bit in grant_wr; active = |grant_wr. All paths combinational, zero added latency.
//  - State st: ADDR (default) or RESP. Registered flags aw_done, w_done.
//  - ADDR, active: s_awvalid = m_awvalid[sel] & ~aw_done; m_awready[sel] = s_awready & ~aw_done.
//    W is the same with w_done. s_awaddr/wdata/wstrb = lane sel. AW and W are independent, either order or the same cycle.
//  - Handshake sets its flag. When both are done, or the last completes this cycle, st -> RESP next edge.
//  - RESP: s_bready = m_bready[sel]; m_bvalid[sel] = s_bvalid. On s_bvalid & s_bready: st -> ADDR, both flags cleared.
//    The arbiter drops grant_wr on the same edge.
//  - Gating: in ADDR, s_bready = 0 and all m_bvalid = 0. In RESP, all AW/W valids and readies = 0.
//  - Unselected lanes: ready/valid = 0 at all times. active = 0: every slave valid and master ready = 0.
//  - Grant stability: grant_wr must stay stable from its assertion through the B handshake.
//    If it changes mid-transaction, st and flags hold (no clearing); this is flagged by a bench assertion.
//  - Reset (aresetn=0 at edge): st = ADDR, aw_done = w_done = 0.
//    Every valid/ready output is 0 while in reset; address/data outputs are don't-care but driven from lane sel or 0.
//    Reset mid-transaction abandons it; no B is forwarded afterwards.
//  - request_wr is not masked during a transaction; the arbiter ignores requests while in ACKN.
// TESTING
//  1 M0 AW+W same cycle, grant_wr=01, s ready=1: both pass in 1 cycle; RESP next cycle.
//    bvalid/bready -> m_bvalid[0]=1, bresp=OKAY; flags cleared.
//  2 W before AW: M1 wvalid at cycle 0, awvalid at cycle 3, grant=10: W accepted cycle 0, AW cycle 3,
//    RESP at cycle 4; no duplicate W toward slave.
//  3 Backpressure: s_awready low 5 cycles then high, s_wready high: W done first;
//    AW forwarded once, s_awvalid held stable; RESP only after AW.
//  4 Early slave B (s_bvalid=1 while in ADDR): s_bready=0, m_bvalid=0 until RESP; then one handshake.
//  5 Both masters requesting, round-robin arbiter: alternating grants 01,10,01; each B returns to the granted
//    master only; unselected lanes stay at 0.
//  6 aresetn low for 1 cycle with aw_done=1 mid-transaction: st=ADDR, flags=0, all valids/readies 0.

Source files
------------

// File: rtl/axil_mux_wr.sv
// AXI-Lite write-path multiplexer: forwards AW/W of the granted master to the single
// slave port and routes the B response back, forwarding each granted transaction once.
module axil_mux_wr #(
    parameter int NUMBER_MASTER   = 2,
    parameter int AXIL_ADDR_WIDTH = 32,
    parameter int AXIL_DATA_WIDTH = 32
) (
    input  logic                                         aclk,
    input  logic                                         aresetn,

    output logic [NUMBER_MASTER-1:0]                     request_wr,
    input  logic [NUMBER_MASTER-1:0]                     grant_wr,

    input  logic [NUMBER_MASTER*AXIL_ADDR_WIDTH-1:0]     m_axil_awaddr,
    input  logic [NUMBER_MASTER-1:0]                     m_axil_awvalid,
    output logic [NUMBER_MASTER-1:0]                     m_axil_awready,
    input  logic [NUMBER_MASTER*AXIL_DATA_WIDTH-1:0]     m_axil_wdata,
    input  logic [NUMBER_MASTER*AXIL_DATA_WIDTH/8-1:0]   m_axil_wstrb,
    input  logic [NUMBER_MASTER-1:0]                     m_axil_wvalid,
    output logic [NUMBER_MASTER-1:0]                     m_axil_wready,
    output logic [NUMBER_MASTER*2-1:0]                   m_axil_bresp,
    output logic [NUMBER_MASTER-1:0]                     m_axil_bvalid,
    input  logic [NUMBER_MASTER-1:0]                     m_axil_bready,

    output logic [AXIL_ADDR_WIDTH-1:0]                   s_axil_awaddr,
    output logic                                         s_axil_awvalid,
    input  logic                                         s_axil_awready,
    output logic [AXIL_DATA_WIDTH-1:0]                   s_axil_wdata,
    output logic [AXIL_DATA_WIDTH/8-1:0]                 s_axil_wstrb,
    output logic                                         s_axil_wvalid,
    input  logic                                         s_axil_wready,
    input  logic [1:0]                                   s_axil_bresp,
    input  logic                                         s_axil_bvalid,
    output logic                                         s_axil_bready
);

    localparam int NM    = NUMBER_MASTER;
    localparam int AW    = AXIL_ADDR_WIDTH;
    localparam int DW    = AXIL_DATA_WIDTH;
    localparam int SW    = AXIL_DATA_WIDTH / 8;
    localparam int SEL_W = (NM > 1) ? $clog2(NM) : 1;

    typedef enum logic {
        ST_ADDR = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t           st;
    state_t           st_next;
    logic             aw_done;
    logic             aw_done_next;
    logic             w_done;
    logic             w_done_next;
    logic [SEL_W-1:0] sel;
    logic             active;
    logic             run;
    logic             aw_hs;
    logic             w_hs;
    logic             b_hs;

    assign request_wr = m_axil_awvalid;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NM; i++) begin
            if (grant_wr[i]) begin
                sel = SEL_W'(i);
            end
        end
    end

    assign active = |grant_wr;
    // Reset also forces every handshake signal low, not just the state.
    assign run    = aresetn & active;

    assign s_axil_awaddr = m_axil_awaddr[int'(sel)*AW +: AW];
    assign s_axil_wdata  = m_axil_wdata[int'(sel)*DW +: DW];
    assign s_axil_wstrb  = m_axil_wstrb[int'(sel)*SW +: SW];
    assign m_axil_bresp  = {NM{s_axil_bresp}};

    always_comb begin
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        s_axil_bready  = 1'b0;
        m_axil_awready = '0;
        m_axil_wready  = '0;
        m_axil_bvalid  = '0;
        if (run) begin
            case (st)
                ST_ADDR: begin
                    s_axil_awvalid      = m_axil_awvalid[sel] & ~aw_done;
                    m_axil_awready[sel] = s_axil_awready & ~aw_done;
                    s_axil_wvalid       = m_axil_wvalid[sel] & ~w_done;
                    m_axil_wready[sel]  = s_axil_wready & ~w_done;
                end
                ST_RESP: begin
                    s_axil_bready       = m_axil_bready[sel];
                    m_axil_bvalid[sel]  = s_axil_bvalid;
                end
                default: begin
                    s_axil_bready       = 1'b0;
                end
            endcase
        end
    end

    assign aw_hs = s_axil_awvalid & s_axil_awready;
    assign w_hs  = s_axil_wvalid & s_axil_wready;
    assign b_hs  = s_axil_bvalid & s_axil_bready;

    // Flags only ever clear on the B handshake, so a grant glitch mid-transaction
    // leaves the progress intact instead of replaying AW or W.
    always_comb begin
        st_next      = st;
        aw_done_next = aw_done;
        w_done_next  = w_done;
        case (st)
            ST_ADDR: begin
                if (aw_hs) begin
                    aw_done_next = 1'b1;
                end
                if (w_hs) begin
                    w_done_next = 1'b1;
                end
                if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                    st_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (b_hs) begin
                    st_next      = ST_ADDR;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                end
            end
            default: begin
                st_next = ST_ADDR;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            st      <= ST_ADDR;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            st      <= st_next;
            aw_done <= aw_done_next;
            w_done  <= w_done_next;
        end
    end

endmodule

// File: tb/tb_axil_mux_wr.sv
// Directed bench for axil_mux_wr with two masters; each scenario task checks
// the combinational routing/gating one step after every driven change.
module tb_axil_mux_wr;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [1:0]  request_wr;
    logic [1:0]  grant_wr;
    logic [63:0] m_axil_awaddr;
    logic [1:0]  m_axil_awvalid;
    logic [1:0]  m_axil_awready;
    logic [63:0] m_axil_wdata;
    logic [7:0]  m_axil_wstrb;
    logic [1:0]  m_axil_wvalid;
    logic [1:0]  m_axil_wready;
    logic [3:0]  m_axil_bresp;
    logic [1:0]  m_axil_bvalid;
    logic [1:0]  m_axil_bready;
    logic [31:0] s_axil_awaddr;
    logic        s_axil_awvalid;
    logic        s_axil_awready;
    logic [31:0] s_axil_wdata;
    logic [3:0]  s_axil_wstrb;
    logic        s_axil_wvalid;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready;

    int n_chk  = 0;
    int n_fail = 0;

    // {s_awvalid, s_wvalid, s_bready, m_awready[1:0], m_wready[1:0], m_bvalid[1:0]}
    logic [8:0] ctrl;
    assign ctrl = {s_axil_awvalid, s_axil_wvalid, s_axil_bready,
                   m_axil_awready, m_axil_wready, m_axil_bvalid};

    axil_mux_wr #(
        .NUMBER_MASTER  (2),
        .AXIL_ADDR_WIDTH(32),
        .AXIL_DATA_WIDTH(32)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .request_wr    (request_wr),
        .grant_wr      (grant_wr),
        .m_axil_awaddr (m_axil_awaddr),
        .m_axil_awvalid(m_axil_awvalid),
        .m_axil_awready(m_axil_awready),
        .m_axil_wdata  (m_axil_wdata),
        .m_axil_wstrb  (m_axil_wstrb),
        .m_axil_wvalid (m_axil_wvalid),
        .m_axil_wready (m_axil_wready),
        .m_axil_bresp  (m_axil_bresp),
        .m_axil_bvalid (m_axil_bvalid),
        .m_axil_bready (m_axil_bready),
        .s_axil_awaddr (s_axil_awaddr),
        .s_axil_awvalid(s_axil_awvalid),
        .s_axil_awready(s_axil_awready),
        .s_axil_wdata  (s_axil_wdata),
        .s_axil_wstrb  (s_axil_wstrb),
        .s_axil_wvalid (s_axil_wvalid),
        .s_axil_wready (s_axil_wready),
        .s_axil_bresp  (s_axil_bresp),
        .s_axil_bvalid (s_axil_bvalid),
        .s_axil_bready (s_axil_bready)
    );

    always #5 aclk = ~aclk;

    // The grant must not move while a transaction is partly done.
    logic [1:0] grant_q;
    always @(posedge aclk) begin
        if (aresetn === 1'b1 && (dut.aw_done === 1'b1 || dut.w_done === 1'b1)
            && grant_wr !== grant_q) begin
            n_fail++;
            $display("FAIL grant_stable: grant %b was %b while busy", grant_wr, grant_q);
        end
        grant_q <= grant_wr;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_inputs();
        grant_wr       = 2'b00;
        m_axil_awvalid = 2'b00;
        m_axil_wvalid  = 2'b00;
        m_axil_bready  = 2'b00;
        s_axil_awready = 1'b0;
        s_axil_wready  = 1'b0;
        s_axil_bvalid  = 1'b0;
        s_axil_bresp   = 2'b00;
    endtask

    task automatic test_reset();
        grant_wr = 2'b01; m_axil_awvalid = 2'b01; m_axil_wvalid = 2'b01;
        s_axil_awready = 1'b1; s_axil_wready = 1'b1; s_axil_bvalid = 1'b1; m_axil_bready = 2'b01;
        #1;
        n_chk++;
        if (ctrl !== 9'b0_0_0_00_00_00) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want %b", ctrl, 9'b0);
        end
        n_chk++;
        if (request_wr !== 2'b01) begin
            n_fail++; $display("FAIL reset_request: got %b want 01", request_wr);
        end
        tick();
        n_chk++;
        if ({dut.aw_done, dut.w_done} !== 2'b00) begin
            n_fail++; $display("FAIL reset_flags: got %b want 00", {dut.aw_done, dut.w_done});
        end
        clear_inputs();
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_same_cycle();
        grant_wr = 2'b01; m_axil_awvalid = 2'b01; m_axil_wvalid = 2'b01;
        s_axil_awready = 1'b1; s_axil_wready = 1'b1; m_axil_bready = 2'b01;
        #1;
        n_chk++;
        if (ctrl !== 9'b1_1_0_01_01_00) begin
            n_fail++; $display("FAIL t1_addr_ctrl: got %b want %b", ctrl, 9'b1_1_0_01_01_00);
        end
        n_chk++;
        if ({s_axil_awaddr, s_axil_wdata, s_axil_wstrb} !== {32'h1000_0010, 32'h1234_5678, 4'hF}) begin
            n_fail++; $display("FAIL t1_lane0_data: got %h %h %h want 10000010 12345678 f",
                               s_axil_awaddr, s_axil_wdata, s_axil_wstrb);
        end
        tick();
        n_chk++;
        if (ctrl !== 9'b0_0_1_00_00_00) begin
            n_fail++; $display("FAIL t1_resp_gate: got %b want %b", ctrl, 9'b0_0_1_00_00_00);
        end
        n_chk++;
        if ({dut.aw_done, dut.w_done} !== 2'b11) begin
            n_fail++; $display("FAIL t1_flags_set: got %b want 11", {dut.aw_done, dut.w_done});
        end
        s_axil_bvalid = 1'b1; s_axil_bresp = 2'b00;
        #1;
        n_chk++;
        if (ctrl !== 9'b0_0_1_00_00_01 || m_axil_bresp !== 4'b0000) begin
            n_fail++; $display("FAIL t1_b_route: got %b/%b want %b/0000", ctrl, m_axil_bresp, 9'b0_0_1_00_00_01);
        end
        tick();
        clear_inputs();
        #1;
        n_chk++;
        if ({dut.aw_done, dut.w_done} !== 2'b00) begin
            n_fail++; $display("FAIL t1_flags_clear: got %b want 00", {dut.aw_done, dut.w_done});
        end
        tick();
    endtask

    task automatic test_w_before_aw();
        grant_wr = 2'b10; m_axil_wvalid = 2'b10; m_axil_awvalid = 2'b00;
        s_axil_awready = 1'b1; s_axil_wready = 1'b1;
        #1;
        n_chk++;
        if (ctrl !== 9'b0_1_0_10_10_00) begin
            n_fail++; $display("FAIL t2_w_first: got %b want %b", ctrl, 9'b0_1_0_10_10_00);
        end
        n_chk++;
        if ({s_axil_wdata, s_axil_wstrb} !== {32'hFFFF_0000, 4'h3}) begin
            n_fail++; $display("FAIL t2_lane1_w: got %h %h want ffff0000 3", s_axil_wdata, s_axil_wstrb);
        end
        tick();
        for (int c = 1; c < 3; c++) begin
            n_chk++;
            if (ctrl !== 9'b0_0_0_10_00_00) begin
                n_fail++; $display("FAIL t2_no_dup_w c%0d: got %b want %b", c, ctrl, 9'b0_0_0_10_00_00);
            end
            tick();
        end
        m_axil_awvalid = 2'b10;
        #1;
        n_chk++;
        if (ctrl !== 9'b1_0_0_10_00_00 || s_axil_awaddr !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL t2_aw_late: got %b %h want %b deadbeef", ctrl, s_axil_awaddr, 9'b1_0_0_10_00_00);
        end
        tick();
        m_axil_bready = 2'b10; s_axil_bvalid = 1'b1; s_axil_bresp = 2'b10;
        #1;
        n_chk++;
        if (ctrl !== 9'b0_0_1_00_00_10 || m_axil_bresp !== 4'b1010) begin
            n_fail++; $display("FAIL t2_b_m1: got %b/%b want %b/1010", ctrl, m_axil_bresp, 9'b0_0_1_00_00_10);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_backpressure();
        m_axil_awaddr[31:0] = 32'hA5A5_0004;
        grant_wr = 2'b01; m_axil_awvalid = 2'b01; m_axil_wvalid = 2'b01;
        s_axil_awready = 1'b0; s_axil_wready = 1'b1; m_axil_bready = 2'b01;
        #1;
        n_chk++;
        if (ctrl !== 9'b1_1_0_00_01_00) begin
            n_fail++; $display("FAIL t3_c0: got %b want %b", ctrl, 9'b1_1_0_00_01_00);
        end
        tick();
        for (int c = 1; c < 5; c++) begin
            n_chk++;
            if (ctrl !== 9'b1_0_0_00_00_00 || s_axil_awaddr !== 32'hA5A5_0004) begin
                n_fail++; $display("FAIL t3_stall c%0d: got %b %h want %b a5a50004", c, ctrl, s_axil_awaddr,
                                   9'b1_0_0_00_00_00);
            end
            tick();
        end
        s_axil_awready = 1'b1;
        #1;
        n_chk++;
        if (ctrl !== 9'b1_0_0_01_00_00) begin
            n_fail++; $display("FAIL t3_aw_accept: got %b want %b", ctrl, 9'b1_0_0_01_00_00);
        end
        tick();
        n_chk++;
        if (ctrl !== 9'b0_0_1_00_00_00) begin
            n_fail++; $display("FAIL t3_resp: got %b want %b", ctrl, 9'b0_0_1_00_00_00);
        end
        s_axil_bvalid = 1'b1;
        tick();
        clear_inputs();
        m_axil_awaddr[31:0] = 32'h1000_0010;
        tick();
    endtask

    task automatic test_early_b();
        s_axil_bvalid = 1'b1; s_axil_bresp = 2'b01;
        grant_wr = 2'b01; m_axil_bready = 2'b01; m_axil_awvalid = 2'b01; m_axil_wvalid = 2'b00;
        s_axil_awready = 1'b1; s_axil_wready = 1'b1;
        #1;
        n_chk++;
        if (ctrl !== 9'b1_0_0_01_01_00) begin
            n_fail++; $display("FAIL t4_b_blocked0: got %b want %b", ctrl, 9'b1_0_0_01_01_00);
        end
        tick();
        n_chk++;
        if (ctrl !== 9'b0_0_0_00_01_00) begin
            n_fail++; $display("FAIL t4_b_blocked1: got %b want %b", ctrl, 9'b0_0_0_00_01_00);
        end
        m_axil_wvalid = 2'b01;
        #1;
        n_chk++;
        if (ctrl !== 9'b0_1_0_00_01_00) begin
            n_fail++; $display("FAIL t4_w_pass: got %b want %b", ctrl, 9'b0_1_0_00_01_00);
        end
        tick();
        m_axil_awvalid = 2'b00; m_axil_wvalid = 2'b00;
        #1;
        n_chk++;
        if (ctrl !== 9'b0_0_1_00_00_01 || m_axil_bresp !== 4'b0101) begin
            n_fail++; $display("FAIL t4_b_pass: got %b/%b want %b/0101", ctrl, m_axil_bresp, 9'b0_0_1_00_00_01);
        end
        tick();
        n_chk++;
        if (ctrl !== 9'b0_0_0_01_01_00) begin
            n_fail++; $display("FAIL t4_single_b: got %b want %b", ctrl, 9'b0_0_0_01_01_00);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0]  g;
        logic [31:0] exp_addr;
        for (int r = 0; r < 3; r++) begin
            g        = (r % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (r % 2 == 0) ? 32'h1000_0010 : 32'hDEAD_BEEF;
            s_axil_bvalid = 1'b0;
            grant_wr = g; m_axil_awvalid = 2'b11; m_axil_wvalid = 2'b11;
            s_axil_awready = 1'b1; s_axil_wready = 1'b1; m_axil_bready = 2'b11;
            #1;
            n_chk++;
            if (ctrl !== {3'b110, g, g, 2'b00} || s_axil_awaddr !== exp_addr || request_wr !== 2'b11) begin
                n_fail++; $display("FAIL t5_addr r%0d: got %b %h %b want %b %h 11", r, ctrl, s_axil_awaddr,
                                   request_wr, {3'b110, g, g, 2'b00}, exp_addr);
            end
            tick();
            s_axil_bvalid = 1'b1;
            #1;
            n_chk++;
            if (ctrl !== {3'b001, 4'b0000, g}) begin
                n_fail++; $display("FAIL t5_b r%0d: got %b want %b", r, ctrl, {3'b001, 4'b0000, g});
            end
            tick();
            grant_wr = 2'b00;
            #1;
            n_chk++;
            if (ctrl !== 9'b0) begin
                n_fail++; $display("FAIL t5_idle r%0d: got %b want %b", r, ctrl, 9'b0);
            end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        grant_wr = 2'b01; m_axil_awvalid = 2'b01; m_axil_wvalid = 2'b00;
        s_axil_awready = 1'b1; s_axil_wready = 1'b1; m_axil_bready = 2'b01;
        tick();
        n_chk++;
        if (dut.aw_done !== 1'b1) begin
            n_fail++; $display("FAIL t6_aw_done: got %b want 1", dut.aw_done);
        end
        aresetn = 1'b0;
        #1;
        n_chk++;
        if (ctrl !== 9'b0) begin
            n_fail++; $display("FAIL t6_in_reset: got %b want %b", ctrl, 9'b0);
        end
        tick();
        aresetn = 1'b1;
        s_axil_bvalid = 1'b1;
        #1;
        n_chk++;
        if ({dut.aw_done, dut.w_done} !== 2'b00) begin
            n_fail++; $display("FAIL t6_flags: got %b want 00", {dut.aw_done, dut.w_done});
        end
        n_chk++;
        if (ctrl !== 9'b1_0_0_01_01_00) begin
            n_fail++; $display("FAIL t6_after: got %b want %b", ctrl, 9'b1_0_0_01_01_00);
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        aresetn       = 1'b0;
        m_axil_awaddr = {32'hDEAD_BEEF, 32'h1000_0010};
        m_axil_wdata  = {32'hFFFF_0000, 32'h1234_5678};
        m_axil_wstrb  = {4'h3, 4'hF};
        clear_inputs();
        tick();
        tick();
        test_reset();
        test_same_cycle();
        test_w_before_aw();
        test_backpressure();
        test_early_b();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
